// File: rtl/pll_rate_sequencer.sv
// pll_rate_sequencer
// Debounces the CPU speed select and the auxiliary divider select. On any
// accepted change, or when the CPU leaves reset, it walks the PLL reconfig
// port through mode / main counter / aux counter / start writes. It then
// waits for lock and publishes the new clock rate in Hz.
//
// Ports:
//   clk_sys, reset_sys       clock, synchronous active-high reset
//   speed_sel, aux_sel       raw (asynchronous) table indices
//   cpu_reset                CPU reset; a falling edge forces reprogramming
//   pll_locked               PLL lock status, only looked at in WAIT_LOCK
//   cfg_waitrequest          reconfig port stall
//   cfg_write/address/data   reconfig port write channel
//   cur_rate                 Hz of the applied speed entry
//   busy                     sequence in progress
//   lock_err                 sticky: last sequence timed out waiting for lock

// Per-select debounce: a value must be sampled STABLE times in a row and be
// a valid table index before it becomes the filtered value.
module pll_rate_sel_filter #(
    parameter int W      = 3,
    parameter int N      = 5,
    parameter int STABLE = 2
) (
    input  logic         clk_sys,
    input  logic         reset_sys,
    input  logic [W-1:0] sel,
    output logic [W-1:0] filt
);
    localparam int CW = $clog2(STABLE + 1);

    logic [W-1:0]  cand;
    logic [CW-1:0] cnt, cnt_nxt;

    always_comb begin
        cnt_nxt = CW'(1);
        if (sel == cand)
            cnt_nxt = (cnt == CW'(STABLE)) ? cnt : cnt + CW'(1);
    end

    always_ff @(posedge clk_sys) begin
        if (reset_sys) begin
            cand <= '0;
            cnt  <= '0;
            filt <= '0;
        end else begin
            cand <= sel;
            cnt  <= cnt_nxt;
            if (cnt_nxt == CW'(STABLE) && int'(sel) < N)
                filt <= sel;
        end
    end
endmodule

module pll_rate_sequencer #(
    parameter int NUM_SPEEDS    = 5,
    parameter int NUM_AUX       = 3,
    parameter int STABLE_CYCLES = 2,
    parameter int LOCK_CYCLES   = 16,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter logic [NUM_SPEEDS*18-1:0] SPEED_DIV =
        {18'h0505, 18'h20504, 18'h1E1E, 18'h0F0F, 18'h0808},
    parameter logic [NUM_AUX*32-1:0] AUX_DIV =
        {32'h40909, 32'h4F4F4, 32'h49696},
    parameter logic [NUM_SPEEDS*28-1:0] CLK_RATE =
        {28'd90000000, 28'd100000000, 28'd15000000, 28'd30000000, 28'd56250000},
    localparam int SW = (NUM_SPEEDS > 1) ? $clog2(NUM_SPEEDS) : 1,
    localparam int AW = (NUM_AUX > 1) ? $clog2(NUM_AUX) : 1
) (
    input  logic          clk_sys,
    input  logic          reset_sys,
    input  logic [SW-1:0] speed_sel,
    input  logic [AW-1:0] aux_sel,
    input  logic          cpu_reset,
    input  logic          pll_locked,
    input  logic          cfg_waitrequest,
    output logic          cfg_write,
    output logic [5:0]    cfg_address,
    output logic [31:0]   cfg_data,
    output logic [27:0]   cur_rate,
    output logic          busy,
    output logic          lock_err
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WR_MODE   = 3'd1;
    localparam logic [2:0] WR_C0     = 3'd2;
    localparam logic [2:0] WR_C1     = 3'd3;
    localparam logic [2:0] WR_START  = 3'd4;
    localparam logic [2:0] WAIT_LOCK = 3'd5;

    localparam int LCW = $clog2(LOCK_CYCLES + 1);
    localparam int TW  = $clog2(LOCK_TIMEOUT + 1);

    // Table entry 0 sits in the MSBs of each packed parameter.
    function automatic logic [31:0] spd_word(input logic [SW-1:0] i);
        return {14'd0, SPEED_DIV[(NUM_SPEEDS-1-int'(i))*18 +: 18]};
    endfunction
    function automatic logic [31:0] aux_word(input logic [AW-1:0] i);
        return AUX_DIV[(NUM_AUX-1-int'(i))*32 +: 32];
    endfunction
    function automatic logic [27:0] rate_word(input logic [SW-1:0] i);
        return CLK_RATE[(NUM_SPEEDS-1-int'(i))*28 +: 28];
    endfunction

    logic [2:0]     state;
    logic [SW-1:0]  filt_spd, tgt_spd;
    logic [AW-1:0]  filt_aux, tgt_aux;
    logic           cpu_q, cpu_qq, pending, trigger;
    logic [LCW-1:0] lock_cnt;
    logic [TW-1:0]  elapsed;

    pll_rate_sel_filter #(.W(SW), .N(NUM_SPEEDS), .STABLE(STABLE_CYCLES)) u_spd_filt (
        .clk_sys(clk_sys), .reset_sys(reset_sys), .sel(speed_sel), .filt(filt_spd));
    pll_rate_sel_filter #(.W(AW), .N(NUM_AUX), .STABLE(STABLE_CYCLES)) u_aux_filt (
        .clk_sys(clk_sys), .reset_sys(reset_sys), .sel(aux_sel), .filt(filt_aux));

    // Targets equal the applied indices whenever IDLE, so comparing against
    // them detects new requests both idle and while a sequence is running.
    assign trigger = (filt_spd != tgt_spd) || (filt_aux != tgt_aux) || (cpu_qq && !cpu_q);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk_sys) begin
        if (reset_sys) begin
            state       <= IDLE;
            cfg_write   <= 1'b0;
            cfg_address <= '0;
            cfg_data    <= '0;
            cur_rate    <= rate_word('0);
            lock_err    <= 1'b0;
            pending     <= 1'b0;
            tgt_spd     <= '0;
            tgt_aux     <= '0;
            cpu_q       <= 1'b0;
            cpu_qq      <= 1'b0;
            lock_cnt    <= '0;
            elapsed     <= '0;
        end else begin
            cpu_q  <= cpu_reset;
            cpu_qq <= cpu_q;
            if (state != IDLE && trigger)
                pending <= 1'b1;

            case (state)
                IDLE: begin
                    if (pending || trigger) begin
                        pending     <= 1'b0;
                        tgt_spd     <= filt_spd;
                        tgt_aux     <= filt_aux;
                        state       <= WR_MODE;
                        cfg_write   <= 1'b1;
                        cfg_address <= 6'd0;
                        cfg_data    <= '0;
                    end
                end
                WR_MODE, WR_C0, WR_C1, WR_START: begin
                    if (cfg_write) begin
                        if (!cfg_waitrequest)
                            cfg_write <= 1'b0;
                    end else begin
                        // Gap cycle after an accepted write: issue the next one.
                        case (state)
                            WR_MODE: begin
                                state       <= WR_C0;
                                cfg_write   <= 1'b1;
                                cfg_address <= 6'd5;
                                cfg_data    <= spd_word(tgt_spd);
                            end
                            WR_C0: begin
                                state       <= WR_C1;
                                cfg_write   <= 1'b1;
                                cfg_address <= 6'd5;
                                cfg_data    <= aux_word(tgt_aux);
                            end
                            WR_C1: begin
                                state       <= WR_START;
                                cfg_write   <= 1'b1;
                                cfg_address <= 6'd2;
                                cfg_data    <= '0;
                            end
                            default: begin
                                state       <= WAIT_LOCK;
                                cfg_address <= 6'd0;
                                lock_cnt    <= '0;
                                elapsed     <= '0;
                            end
                        endcase
                    end
                end
                WAIT_LOCK: begin
                    elapsed  <= elapsed + TW'(1);
                    lock_cnt <= pll_locked ? lock_cnt + LCW'(1) : '0;
                    // A timed-out sequence still applies the new rate; the
                    // sticky flag tells software the PLL never confirmed it.
                    if (pll_locked && lock_cnt == LCW'(LOCK_CYCLES - 1)) begin
                        state    <= IDLE;
                        cur_rate <= rate_word(tgt_spd);
                        lock_err <= 1'b0;
                    end else if (elapsed == TW'(LOCK_TIMEOUT - 1)) begin
                        state    <= IDLE;
                        cur_rate <= rate_word(tgt_spd);
                        lock_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pll_rate_sequencer.sv
module tb_pll_rate_sequencer;
    logic        clk_sys = 1'b0;
    logic        reset_sys = 1'b1;
    logic [2:0]  speed_sel = '0;
    logic [1:0]  aux_sel = '0;
    logic        cpu_reset = 1'b0;
    logic        pll_locked = 1'b1;
    logic        cfg_waitrequest = 1'b0;
    logic        cfg_write;
    logic [5:0]  cfg_address;
    logic [31:0] cfg_data;
    logic [27:0] cur_rate;
    logic        busy;
    logic        lock_err;

    pll_rate_sequencer dut (
        .clk_sys(clk_sys), .reset_sys(reset_sys), .speed_sel(speed_sel),
        .aux_sel(aux_sel), .cpu_reset(cpu_reset), .pll_locked(pll_locked),
        .cfg_waitrequest(cfg_waitrequest), .cfg_write(cfg_write),
        .cfg_address(cfg_address), .cfg_data(cfg_data), .cur_rate(cur_rate),
        .busy(busy), .lock_err(lock_err));

    always #5 clk_sys = ~clk_sys;

    int total = 0;
    int bad = 0;

    typedef struct { logic [5:0] a; logic [31:0] d; } wr_t;
    wr_t wq[$];

    typedef struct {
        logic [2:0]  spd;
        logic [1:0]  aux;
        int          nwr;
        logic [31:0] c0;
        logic [31:0] c1;
        logic [27:0] rate;
    } vec_t;
    vec_t tab[7];

    logic [31:0] spd_tab[5];
    logic [31:0] aux_tab[3];
    logic [27:0] rate_tab[5];

    // Reference model state: accepted selects from the sample stream.
    bit model_on = 0;
    bit rnd_drv = 0;
    int run_s, len_s, m_spd, run_a, len_a, m_aux;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        if (model_on) begin
            if (int'(speed_sel) == run_s) len_s++; else begin run_s = int'(speed_sel); len_s = 1; end
            if (len_s >= 2 && run_s < 5) m_spd = run_s;
            if (int'(aux_sel) == run_a) len_a++; else begin run_a = int'(aux_sel); len_a = 1; end
            if (len_a >= 2 && run_a < 3) m_aux = run_a;
        end
        #1;
        if (rnd_drv) begin
            cfg_waitrequest = ($urandom_range(0, 3) == 0);
            pll_locked = ($urandom_range(0, 7) != 0);
        end
    endtask

    // Let any trigger start, then require 8 consecutive idle cycles.
    task automatic wait_idle(input int budget, input string nm);
        int quiet = 0;
        int n = 0;
        repeat (12) tick();
        while (quiet < 8 && n < budget) begin
            tick();
            n++;
            if (!busy) quiet++; else quiet = 0;
        end
        chk({nm, "_idle_timeout"}, 64'(quiet >= 8), 64'd1);
    endtask

    task automatic wait_wr(input logic [31:0] d, input string nm);
        int n = 0;
        bit hit = 0;
        while (!hit && n < 200) begin
            tick();
            n++;
            hit = cfg_write && cfg_address == 6'd5 && cfg_data == d;
        end
        chk({nm, "_wr_seen"}, 64'(hit), 64'd1);
    endtask

    task automatic check_group(input int base, input logic [31:0] c0, input logic [31:0] c1, input string nm);
        if (wq.size() >= base + 4) begin
            chk({nm, "_a0"}, 64'(wq[base].a), 64'd0);
            chk({nm, "_d0"}, 64'(wq[base].d), 64'd0);
            chk({nm, "_a1"}, 64'(wq[base+1].a), 64'd5);
            chk({nm, "_d1"}, 64'(wq[base+1].d), 64'(c0));
            chk({nm, "_a2"}, 64'(wq[base+2].a), 64'd5);
            chk({nm, "_d2"}, 64'(wq[base+2].d), 64'(c1));
            chk({nm, "_a3"}, 64'(wq[base+3].a), 64'd2);
            chk({nm, "_d3"}, 64'(wq[base+3].d), 64'd0);
        end
    endtask

    // Port protocol monitor, sampled mid-cycle.
    logic        prev_stall = 0, prev_acc = 0, prev_busy = 0, prev_rst = 1;
    logic [5:0]  prev_addr = '0;
    logic [31:0] prev_data = '0;
    logic [27:0] prev_rate = '0;

    always @(negedge clk_sys) begin
        if (!reset_sys && !prev_rst) begin
            if (prev_stall) begin
                chk("hold_write", 64'(cfg_write), 64'd1);
                chk("hold_addr", 64'(cfg_address), 64'(prev_addr));
                chk("hold_data", 64'(cfg_data), 64'(prev_data));
            end
            if (prev_acc) chk("gap_cycle", 64'(cfg_write), 64'd0);
            if (busy && !prev_busy) chk("busy_rise_with_write", 64'(cfg_write), 64'd1);
            if (cur_rate !== prev_rate) chk("rate_only_on_exit", 64'({prev_busy, busy}), 64'd2);
        end
        if (!reset_sys && cfg_write && !cfg_waitrequest)
            wq.push_back('{a: cfg_address, d: cfg_data});
        prev_stall <= !reset_sys && cfg_write && cfg_waitrequest;
        prev_acc   <= !reset_sys && cfg_write && !cfg_waitrequest;
        prev_busy  <= busy;
        prev_rst   <= reset_sys;
        prev_addr  <= cfg_address;
        prev_data  <= cfg_data;
        prev_rate  <= cur_rate;
    end

    initial begin
        spd_tab  = '{32'h0505, 32'h20504, 32'h1E1E, 32'h0F0F, 32'h0808};
        aux_tab  = '{32'h40909, 32'h4F4F4, 32'h49696};
        rate_tab = '{28'd90000000, 28'd100000000, 28'd15000000, 28'd30000000, 28'd56250000};
        tab[0] = '{spd: 3'd3, aux: 2'd0, nwr: 4, c0: 32'h0F0F,  c1: 32'h40909, rate: 28'd30000000};
        tab[1] = '{spd: 3'd4, aux: 2'd0, nwr: 4, c0: 32'h0808,  c1: 32'h40909, rate: 28'd56250000};
        tab[2] = '{spd: 3'd7, aux: 2'd0, nwr: 0, c0: 32'h0,     c1: 32'h0,     rate: 28'd56250000};
        tab[3] = '{spd: 3'd1, aux: 2'd2, nwr: 4, c0: 32'h20504, c1: 32'h49696, rate: 28'd100000000};
        tab[4] = '{spd: 3'd1, aux: 2'd3, nwr: 0, c0: 32'h0,     c1: 32'h0,     rate: 28'd100000000};
        tab[5] = '{spd: 3'd0, aux: 2'd1, nwr: 4, c0: 32'h0505,  c1: 32'h4F4F4, rate: 28'd90000000};
        tab[6] = '{spd: 3'd2, aux: 2'd1, nwr: 4, c0: 32'h1E1E,  c1: 32'h4F4F4, rate: 28'd15000000};

        // Reset state
        repeat (3) tick();
        chk("rst_write", 64'(cfg_write), 64'd0);
        chk("rst_addr", 64'(cfg_address), 64'd0);
        chk("rst_data", 64'(cfg_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_lock_err", 64'(lock_err), 64'd0);
        chk("rst_rate", 64'(cur_rate), 64'd90000000);
        reset_sys = 1'b0;
        repeat (4) tick();

        // Table-driven select changes
        for (int i = 0; i < 7; i++) begin
            wq.delete();
            speed_sel = tab[i].spd;
            aux_sel = tab[i].aux;
            wait_idle(400, "tab");
            chk($sformatf("tab%0d_nwr", i), 64'(wq.size()), 64'(tab[i].nwr));
            if (tab[i].nwr == 4) check_group(0, tab[i].c0, tab[i].c1, $sformatf("tab%0d", i));
            chk($sformatf("tab%0d_rate", i), 64'(cur_rate), 64'(tab[i].rate));
            chk($sformatf("tab%0d_lock_err", i), 64'(lock_err), 64'd0);
        end

        // Waitrequest held for 5 cycles on the main-counter write
        wq.delete();
        speed_sel = 3'd3;
        aux_sel = 2'd0;
        wait_wr(32'h0F0F, "stall");
        cfg_waitrequest = 1'b1;
        repeat (5) begin
            tick();
            chk("stall_write", 64'(cfg_write), 64'd1);
            chk("stall_addr", 64'(cfg_address), 64'd5);
            chk("stall_data", 64'(cfg_data), 64'h0F0F);
        end
        cfg_waitrequest = 1'b0;
        tick();
        chk("stall_released_gap", 64'(cfg_write), 64'd0);
        wait_idle(400, "stall");
        chk("stall_nwr", 64'(wq.size()), 64'd4);
        check_group(0, 32'h0F0F, 32'h40909, "stall");

        // Toggling select never settles, then 4 is accepted
        wq.delete();
        for (int i = 0; i < 6; i++) begin
            speed_sel = (i % 2) ? 3'd2 : 3'd1;
            tick();
        end
        speed_sel = 3'd4;
        tick();
        chk("toggle_no_busy", 64'(busy), 64'd0);
        chk("toggle_no_writes", 64'(wq.size()), 64'd0);
        wait_idle(400, "toggle");
        chk("toggle_nwr", 64'(wq.size()), 64'd4);
        check_group(0, 32'h0808, 32'h40909, "toggle");
        chk("toggle_rate", 64'(cur_rate), 64'd56250000);

        // Change both selects mid-sequence: one rerun with the latest values
        wq.delete();
        speed_sel = 3'd3;
        wait_wr(32'h40909, "coal");
        speed_sel = 3'd1;
        aux_sel = 2'd2;
        wait_idle(800, "coal");
        chk("coal_nwr", 64'(wq.size()), 64'd8);
        check_group(0, 32'h0F0F, 32'h40909, "coal_first");
        check_group(4, 32'h20504, 32'h49696, "coal_second");
        chk("coal_rate", 64'(cur_rate), 64'd100000000);

        // CPU reset release with unchanged selects
        wq.delete();
        cpu_reset = 1'b1;
        repeat (3) tick();
        cpu_reset = 1'b0;
        wait_idle(400, "cpurst");
        chk("cpurst_nwr", 64'(wq.size()), 64'd4);
        check_group(0, 32'h20504, 32'h49696, "cpurst");
        chk("cpurst_rate", 64'(cur_rate), 64'd100000000);

        // System reset in the middle of a sequence
        cpu_reset = 1'b1;
        repeat (3) tick();
        cpu_reset = 1'b0;
        wait_wr(32'h49696, "midrst");
        reset_sys = 1'b1;
        tick();
        chk("midrst_write", 64'(cfg_write), 64'd0);
        chk("midrst_addr", 64'(cfg_address), 64'd0);
        chk("midrst_data", 64'(cfg_data), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_rate", 64'(cur_rate), 64'd90000000);
        repeat (3) begin
            tick();
            chk("midrst_held_write", 64'(cfg_write), 64'd0);
        end
        speed_sel = 3'd0;
        aux_sel = 2'd0;
        reset_sys = 1'b0;
        wq.delete();
        wait_idle(400, "midrst");
        chk("midrst_no_writes", 64'(wq.size()), 64'd0);

        // Lock never arrives: timeout still applies the rate
        wq.delete();
        pll_locked = 1'b0;
        speed_sel = 3'd2;
        wait_idle(70000, "tmo");
        chk("tmo_lock_err", 64'(lock_err), 64'd1);
        chk("tmo_rate", 64'(cur_rate), 64'd15000000);
        chk("tmo_busy", 64'(busy), 64'd0);
        check_group(0, 32'h1E1E, 32'h40909, "tmo");
        pll_locked = 1'b1;
        speed_sel = 3'd3;
        wait_idle(400, "tmo_clear");
        chk("tmo_clear_lock_err", 64'(lock_err), 64'd0);
        chk("tmo_clear_rate", 64'(cur_rate), 64'd30000000);

        // Random select bursts against the model
        run_s = 3; len_s = 100; m_spd = 3;
        run_a = 0; len_a = 100; m_aux = 0;
        model_on = 1;
        for (int it = 0; it < 25; it++) begin
            wq.delete();
            rnd_drv = 1;
            repeat ($urandom_range(1, 5)) begin
                speed_sel = 3'($urandom_range(0, 7));
                aux_sel = 2'($urandom_range(0, 3));
                repeat ($urandom_range(1, 10)) tick();
            end
            rnd_drv = 0;
            cfg_waitrequest = 1'b0;
            pll_locked = 1'b1;
            wait_idle(3000, "rnd");
            chk($sformatf("rnd%0d_rate", it), 64'(cur_rate), 64'(rate_tab[m_spd]));
            chk($sformatf("rnd%0d_lock_err", it), 64'(lock_err), 64'd0);
            if (wq.size() > 0) begin
                chk($sformatf("rnd%0d_whole_groups", it), 64'(wq.size() % 4), 64'd0);
                check_group(wq.size() - 4, spd_tab[m_spd], aux_tab[m_aux], $sformatf("rnd%0d_last", it));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
